// File: rtl/rel_pos_encoder.sv
// rel_pos_encoder: relative cell position encoder feeding the fixed-to-float
// position converter. Each axis word is {cell_id, offset}, where cell_id is
// 01 = left, 10 = centre and 11 = right neighbour cell. The wrap is periodic.
// The block is a two-stage valid/ready pipeline. A beat whose cells are not
// adjacent is dropped and counted instead of being emitted.
module rel_pos_encoder #(
    parameter int DATA_WIDTH       = 27,
    parameter int CELL_ID_WIDTH    = 2,
    parameter int OFFSET_WIDTH     = DATA_WIDTH - CELL_ID_WIDTH,
    parameter int CELL_COORD_WIDTH = 3,
    parameter int X_DIM            = 4,
    parameter int Y_DIM            = 4,
    parameter int Z_DIM            = 4,
    parameter int ERR_CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3*CELL_COORD_WIDTH-1:0] home_cell,
    input  logic [3*CELL_COORD_WIDTH-1:0] nb_cell,
    input  logic [3*OFFSET_WIDTH-1:0]     offset,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3*DATA_WIDTH-1:0]       out_pos,
    output logic                          err_pulse,
    output logic [ERR_CNT_WIDTH-1:0]      err_count
);

    // One extra bit so that nb-home is representable as a signed value.
    localparam int CW1 = CELL_COORD_WIDTH + 1;

    // The class encoding is the cell_id code itself; 00 marks a non-adjacent axis.
    typedef enum logic [CELL_ID_WIDTH-1:0] {
        CLS_BAD    = 2'b00,
        CLS_LEFT   = 2'b01,
        CLS_CENTRE = 2'b10,
        CLS_RIGHT  = 2'b11
    } cls_t;

    // Cell count of axis a (0 = x, 1 = y, 2 = z).
    function automatic logic [CW1-1:0] dim_of(input int a);
        case (a)
            0:       return CW1'(X_DIM);
            1:       return CW1'(Y_DIM);
            default: return CW1'(Z_DIM);
        endcase
    endfunction

    // Relative cell class along one axis, with periodic wrap. A coordinate
    // outside the axis range makes the axis BAD.
    function automatic cls_t classify(input logic [CELL_COORD_WIDTH-1:0] home,
                                      input logic [CELL_COORD_WIDTH-1:0] nb,
                                      input logic [CW1-1:0]              dim);
        logic signed [CW1-1:0] d;
        cls_t                  cls;
        d = $signed({1'b0, nb}) - $signed({1'b0, home});
        if (d[CW1-1]) d = d + $signed(dim);
        if (({1'b0, home} >= dim) || ({1'b0, nb} >= dim))
            cls = CLS_BAD;
        else if (d == $signed(CW1'(0)))
            cls = CLS_CENTRE;
        else if (d == $signed(CW1'(1)))
            cls = CLS_RIGHT;
        else if (d == $signed(dim - CW1'(1)))
            cls = CLS_LEFT;
        else
            cls = CLS_BAD;
        return cls;
    endfunction

    // Increment the drop counter, holding at all-ones.
    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    logic [2:0][CELL_COORD_WIDTH-1:0] home_ax;
    logic [2:0][CELL_COORD_WIDTH-1:0] nb_ax;
    logic [2:0][OFFSET_WIDTH-1:0]     off_ax;
    cls_t [2:0]                       cls_in;
    logic                             bad_in;

    logic                             vld_p1;
    cls_t [2:0]                       cls_p1;
    logic [2:0][OFFSET_WIDTH-1:0]     off_p1;
    logic                             bad_p1;

    logic                             vld_p2;
    logic [2:0][DATA_WIDTH-1:0]       pos_p2;

    logic                             s1_advance;
    logic                             in_fire;

    assign home_ax    = home_cell;
    assign nb_ax      = nb_cell;
    assign off_ax     = offset;

    assign s1_advance = !vld_p2 || out_ready;
    assign in_ready   = !vld_p1 || s1_advance;
    assign in_fire    = in_valid && in_ready;

    assign out_valid  = vld_p2;
    assign out_pos    = pos_p2;

    // Classify every axis of the incoming beat; one bad axis makes the beat bad.
    always_comb begin
        cls_in = {3{CLS_BAD}};
        bad_in = 1'b0;
        for (int a = 0; a < 3; a++) begin
            cls_in[a] = classify(home_ax[a], nb_ax[a], dim_of(a));
            if (cls_in[a] == CLS_BAD) bad_in = 1'b1;
        end
    end

    // ---- stage 1: accepted beat (class, offsets, bad flag) ----
    // Stage 1 occupancy: fill on accept, empty when the beat moves on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            vld_p1 <= 1'b0;
        else if (in_fire)
            vld_p1 <= 1'b1;
        else if (s1_advance)
            vld_p1 <= 1'b0;
    end

    // Stage 1 payload; it only matters while vld_p1 is set.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            cls_p1 <= cls_in;
            off_p1 <= off_ax;
            bad_p1 <= bad_in;
        end
    end

    // ---- stage 2: output register, drop accounting ----
    // Emit good beats as {code, offset} words; drop bad beats and count them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2    <= 1'b0;
            pos_p2    <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (s1_advance) begin
                vld_p2 <= vld_p1 && !bad_p1;
                if (vld_p1 && !bad_p1) begin
                    for (int a = 0; a < 3; a++)
                        pos_p2[a] <= {cls_p1[a], off_p1[a]};
                end
                if (vld_p1 && bad_p1) begin
                    err_pulse <= 1'b1;
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

endmodule
